// File: rtl/instr_seq_pkg.sv
// Shared opcode, ALU-select and state definitions for the instruction sequencer.
package instr_seq_pkg;

    localparam int unsigned INSTR_W = 16;

    localparam logic [3:0] OP_REG = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_MOV = 4'b1101;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_XOR = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd4;
    localparam logic [3:0] ALU_CMP = 4'd5;
    localparam logic [3:0] ALU_MOV = 4'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       sign_ext;
        logic [3:0] alu;
    } dec_t;

endpackage

// File: rtl/instr_sequencer_imm_ext.sv
// Sign- or zero-extends an 8-bit immediate to the datapath width.
module imm_ext #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [7:0]            imm,
    input  logic                  sign_ext,
    output logic [DATA_WIDTH-1:0] value_c
);

    always_comb begin
        value_c = DATA_WIDTH'(imm);
        if (sign_ext) begin
            value_c = DATA_WIDTH'($signed(imm));
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Four-state instruction sequencer: decode, flag enables, write-back and retire count.
// Optional one-entry skid buffer enabled by defining INSTR_SEQ_SKID_EN.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned REGBITS    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instr,
    output logic                  instr_ready,
    output logic [REGBITS-1:0]    rf_addr1,
    output logic [REGBITS-1:0]    rf_addr2,
    output logic                  rf_wr_en,
    output logic [3:0]            alu_select,
    output logic [DATA_WIDTH-1:0] imm_out,
    output logic                  use_imm,
    output logic                  cmp_f_en,
    output logic                  of_f_en,
    output logic                  z_f_en,
    output logic                  done,
    output logic                  illegal,
    output logic [15:0]           retired_cnt
);

    state_t                state;
    state_t                state_n;
    logic                  accept_c;
    logic                  load_c;
    logic [INSTR_W-1:0]    load_word_c;
    logic                  ready_n_c;
    logic [3:0]            opcode_c;
    logic [3:0]            code_c;
    logic                  is_reg_c;
    dec_t                  dec_c;
    logic [DATA_WIDTH-1:0] ext_value_c;

`ifdef INSTR_SEQ_SKID_EN
    logic               buf_valid;
    logic [INSTR_W-1:0] buf_word;
    logic               buf_set_c;
    logic               buf_clr_c;
    logic               buf_valid_n_c;
`endif

    assign accept_c = instr_valid && instr_ready;

    // Next state and which word (input or buffered) gets loaded this edge
    always_comb begin
        state_n     = state;
        load_c      = 1'b0;
        load_word_c = instr;
`ifdef INSTR_SEQ_SKID_EN
        buf_set_c   = 1'b0;
        buf_clr_c   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
`ifdef INSTR_SEQ_SKID_EN
                if (buf_valid) begin
                    state_n     = S_DECODE;
                    load_c      = 1'b1;
                    load_word_c = buf_word;
                    buf_clr_c   = 1'b1;
                end else if (accept_c) begin
                    state_n = S_DECODE;
                    load_c  = 1'b1;
                end
`else
                if (accept_c) begin
                    state_n = S_DECODE;
                    load_c  = 1'b1;
                end
`endif
            end
            S_DECODE: begin
                state_n = illegal ? S_IDLE : S_EXEC;
`ifdef INSTR_SEQ_SKID_EN
                buf_set_c = accept_c;
`endif
            end
            S_EXEC: begin
                state_n = S_WB;
`ifdef INSTR_SEQ_SKID_EN
                buf_set_c = accept_c;
`endif
            end
            S_WB: begin
                state_n = S_IDLE;
`ifdef INSTR_SEQ_SKID_EN
                if (buf_valid) begin
                    state_n     = S_DECODE;
                    load_c      = 1'b1;
                    load_word_c = buf_word;
                    buf_clr_c   = 1'b1;
                end
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef INSTR_SEQ_SKID_EN
    assign buf_valid_n_c = (buf_valid && !buf_clr_c) || buf_set_c;
    assign ready_n_c     = !buf_valid_n_c && (state_n != S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_word  <= '0;
        end else begin
            buf_valid <= buf_valid_n_c;
            if (buf_set_c) begin
                buf_word <= instr;
            end
        end
    end
`else
    assign ready_n_c = (state_n == S_IDLE);
`endif

    // Instruction decode of the word being loaded
    always_comb begin
        opcode_c = load_word_c[15:12];
        is_reg_c = (opcode_c == OP_REG);
        code_c   = is_reg_c ? load_word_c[7:4] : opcode_c;
        dec_c    = '0;
        case (code_c)
            OP_AND:  dec_c = '{legal: 1'b1, sign_ext: 1'b0, alu: ALU_AND};
            OP_OR:   dec_c = '{legal: 1'b1, sign_ext: 1'b0, alu: ALU_OR};
            OP_XOR:  dec_c = '{legal: 1'b1, sign_ext: 1'b0, alu: ALU_XOR};
            OP_ADD:  dec_c = '{legal: 1'b1, sign_ext: 1'b1, alu: ALU_ADD};
            OP_SUB:  dec_c = '{legal: 1'b1, sign_ext: 1'b1, alu: ALU_SUB};
            OP_CMP:  dec_c = '{legal: 1'b1, sign_ext: 1'b1, alu: ALU_CMP};
            OP_MOV:  dec_c = '{legal: 1'b1, sign_ext: 1'b0, alu: ALU_MOV};
            default: dec_c = '0;
        endcase
    end

    imm_ext #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_imm_ext (
        .imm      (load_word_c[7:0]),
        .sign_ext (dec_c.sign_ext),
        .value_c  (ext_value_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Registered outputs; decoded fields hold until the next load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_ready <= 1'b0;
            rf_addr1    <= '0;
            rf_addr2    <= '0;
            rf_wr_en    <= 1'b0;
            alu_select  <= '0;
            imm_out     <= '0;
            use_imm     <= 1'b0;
            cmp_f_en    <= 1'b0;
            of_f_en     <= 1'b0;
            z_f_en      <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            retired_cnt <= '0;
        end else begin
            instr_ready <= ready_n_c;
            illegal     <= 1'b0;
            if (load_c) begin
                rf_addr1   <= REGBITS'(load_word_c[11:8]);
                rf_addr2   <= REGBITS'(load_word_c[3:0]);
                alu_select <= dec_c.alu;
                use_imm    <= !is_reg_c;
                imm_out    <= is_reg_c ? '0 : ext_value_c;
                illegal    <= !dec_c.legal;
            end
            z_f_en   <= (state_n == S_EXEC) &&
                        (alu_select inside {ALU_ADD, ALU_SUB, ALU_CMP});
            of_f_en  <= (state_n == S_EXEC) && (alu_select inside {ALU_ADD, ALU_SUB});
            cmp_f_en <= (state_n == S_EXEC) && (alu_select inside {ALU_SUB, ALU_CMP});
            rf_wr_en <= (state_n == S_WB) && (alu_select != ALU_CMP);
            done     <= (state_n == S_WB);
            if (state_n == S_WB) begin
                retired_cnt <= retired_cnt + 16'd1;
            end
        end
    end

endmodule
